// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button pins in, conditioned button events out.
// The master drives the raw pins; the slave (the conditioner) drives the events.
interface btn_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_fall;
    logic [NUM_BTN-1:0] btn_toggle;
    logic [NUM_BTN-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_toggle,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_toggle,
        output btn_long
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button 2-flop synchroniser, debounce FSM, edge pulses, toggle.
// Optional long-press pulse is compiled in with `define BTN_LONGPRESS_EN.
module btn_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int LONG_CYCLES     = 100000000,
    parameter int LONG_W          = 27
) (
    input  logic                clk,
    input  logic                reset,
    btn_conditioner_if.slave    bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  LP_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("btn_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if ((64'd1 << LONG_W) < 64'(LONG_CYCLES)) begin : g_bad_long_w
        $error("btn_conditioner: LONG_W too narrow for LONG_CYCLES");
    end

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_fall;
    logic [NUM_BTN-1:0] w_toggle;
    logic [NUM_BTN-1:0] w_long;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch

        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic             r_toggle;

        // Bring the asynchronous pin into the clk domain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= bus.btn_in[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce FSM; a level is accepted only after DEBOUNCE_CYCLES steady samples.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= STABLE_LO;
                r_cnt    <= '0;
                r_level  <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_toggle <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                unique case (r_state)
                    STABLE_LO: begin
                        if (r_sync2) begin
                            r_state <= CHK_HI;
                            r_cnt   <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!r_sync2) begin
                            r_state <= STABLE_LO;
                        end else if (r_cnt == LP_DEB_LAST) begin
                            r_state  <= STABLE_HI;
                            r_level  <= 1'b1;
                            r_rise   <= 1'b1;
                            r_toggle <= ~r_toggle;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        if (!r_sync2) begin
                            r_state <= CHK_LO;
                            r_cnt   <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (r_sync2) begin
                            r_state <= STABLE_HI;
                        end else if (r_cnt == LP_DEB_LAST) begin
                            r_state <= STABLE_LO;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_level[g]  = r_level;
        assign w_rise[g]   = r_rise;
        assign w_fall[g]   = r_fall;
        assign w_toggle[g] = r_toggle;

`ifdef BTN_LONGPRESS_EN
        localparam logic [LONG_W-1:0] LP_LONG_LAST = LONG_W'(LONG_CYCLES - 1);

        logic [LONG_W-1:0] r_lcnt;
        logic              r_ldone;
        logic              r_long;

        // Count hold time in STABLE_HI; fire once per stay, then saturate.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_lcnt  <= '0;
                r_ldone <= 1'b0;
                r_long  <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (r_state == STABLE_HI) begin
                    if (r_lcnt == LP_LONG_LAST) begin
                        if (!r_ldone) begin
                            r_long  <= 1'b1;
                            r_ldone <= 1'b1;
                        end
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end else begin
                    r_lcnt  <= '0;
                    r_ldone <= 1'b0;
                end
            end
        end

        assign w_long[g] = r_long;
`else
        assign w_long[g] = 1'b0;
`endif
    end

    assign bus.btn_level  = w_level;
    assign bus.btn_rise   = w_rise;
    assign bus.btn_fall   = w_fall;
    assign bus.btn_toggle = w_toggle;
    assign bus.btn_long   = w_long;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage for the board push-buttons (BTNU, BTNC).
- Synchronises each raw button to clk, debounces it, and produces a clean level, one-cycle rise/fall pulses and a press-toggled state.
- Outputs feed the speed-select mux and the pause gating downstream.
- They replace the raw single-flop sampling of the buttons.

Parameters:
- NUM_BTN, 2, number of independent button channels (bit 0 = BTNU, bit 1 = BTNC).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range is 2 or more.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- LONG_CYCLES, 100000000, hold time for a long-press pulse (1 s); used only with the optional feature.
- LONG_W, 27, long-press counter width; must satisfy 2^LONG_W >= LONG_CYCLES.

Ports:
- clk, input, 1, system clock; all state is on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- btn_in, input, NUM_BTN, raw asynchronous button pins, active-high.
- btn_level, output, NUM_BTN, debounced button level.
- btn_rise, output, NUM_BTN, one-cycle pulse on accepted press.
- btn_fall, output, NUM_BTN, one-cycle pulse on accepted release.
- btn_toggle, output, NUM_BTN, flips on every accepted press.
- btn_long, output, NUM_BTN, one-cycle long-press pulse; driven 0 when the feature is compiled out.

Behaviour:
- Reset (reset = 0, asynchronous): sync flops, counters, FSMs and all outputs clear to 0. Deassertion takes effect at the next clk edge.
- Per channel, a 2-flop synchroniser sync1 -> sync2 feeds an FSM. "s" denotes sync2.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. Reset state is STABLE_LO.
  - STABLE_LO: s = 1 -> CHK_HI, cnt <= 0.
  - CHK_HI: s = 0 -> STABLE_LO (bounce rejected, no output change). Otherwise, if cnt == DEBOUNCE_CYCLES-1 -> STABLE_HI, else cnt <= cnt+1.
  - STABLE_HI: s = 0 -> CHK_LO, cnt <= 0.
  - CHK_LO: mirror of CHK_HI toward STABLE_LO.
- Outputs are registered:
  - On the CHK_HI -> STABLE_HI edge: btn_level <= 1, btn_rise <= 1 for exactly one cycle, btn_toggle <= ~btn_toggle.
  - On the CHK_LO -> STABLE_LO edge: btn_level <= 0, btn_fall <= 1 for exactly one cycle.
- Latency: if btn_in goes high before edge k and stays high, btn_level/btn_rise are high after edge k+2+DEBOUNCE_CYCLES.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the check. No pulse is emitted and btn_level keeps its old value.
- Counter never wraps: it is compared to DEBOUNCE_CYCLES-1 and held or cleared, never incremented past that value.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- rise and fall never assert in the same cycle on one channel.
- Reset mid-debounce discards the partial count. btn_toggle returns to 0.

Optional Feature:
- Macro: BTN_LONGPRESS_EN.
- Defined:
  - A per-channel long counter clears on entry to STABLE_HI and increments while in STABLE_HI, saturating.
  - When it reaches LONG_CYCLES-1, btn_long pulses for one cycle. At most one pulse per press.
  - The counter clears on leaving STABLE_HI and on reset.
- Undefined: no long counters are instantiated; btn_long is tied to 0.

Test Plan (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10, NUM_BTN = 2):
- Reset: hold reset = 0 with btn_in = 2'b11 -> all outputs 0. Release reset and keep btn_in = 2'b11 -> btn_level = 2'b11, single btn_rise = 2'b11 and btn_toggle = 2'b11 exactly 6 edges after release.
- Clean press/release: btn_in[0] high for 20 cycles then low -> btn_rise[0] pulses once 6 edges after the rise, btn_fall[0] pulses once 6 edges after the fall. Each pulse is exactly 1 cycle wide.
- Bounce rejection: btn_in[1] toggles 1,0,1,0 every 2 cycles, then stays high -> no pulses during the bounce. One btn_rise[1] arrives 6 edges after the final rising edge.
- Toggle: three accepted presses on ch0 -> btn_toggle[0] sequence 1,0,1. ch1 btn_toggle unchanged.
- Reset mid-operation: assert reset during CHK_HI (cycle 3 of the debounce) -> outputs 0 immediately, no pulse. After release with input still high, a full 6-edge debounce is required.
- Long press (BTN_LONGPRESS_EN defined): hold ch0 for 30 cycles -> btn_long[0] pulses once, 10 edges after btn_rise[0]. Without the macro, btn_long stays 2'b00.
